rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Writeback stage that produces the register file's write port (data, register number, write strobe) from two result producers: the ALU result channel and the load unit (LSU) result channel.
- Each channel has a one-entry buffer and a valid/ready handshake.
- When both channels have results, a round-robin arbiter chooses one.
- Load data is sign/zero extended here before the write.

Parameters:
- XLEN, 32, data width of all result and write data.
- REGNO_W, 6, width of register number fields; matches the register file port width.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_alu_valid  input  1  ALU result available.
- o_alu_ready  output  1  ALU entry accepted when valid & ready at the clock edge.
- i_alu_rd  input  REGNO_W  ALU destination register.
- i_alu_dat  input  XLEN  ALU result.
- i_lsu_valid  input  1  load result available.
- o_lsu_ready  output  1  load accept.
- i_lsu_rd  input  REGNO_W  load destination register.
- i_lsu_word  input  XLEN  raw aligned memory word.
- i_lsu_off  input  2  byte offset (addr[1:0]).
- i_lsu_funct3  input  3  load type.
- o_rd_dat  output  XLEN  register file write data.
- o_rd_no  output  REGNO_W  register file write index.
- o_write  output  1  register file write strobe.
- o_illegal_rd  output  1  one-cycle pulse: dropped entry with rd >= 32.
- o_misalign  output  1  one-cycle pulse: dropped misaligned load.

Behaviour:
- Reset (i_rst high at edge):
  - both buffers empty; rr pointer = LSU.
  - o_write=0, o_rd_no=0, o_rd_dat=0, o_illegal_rd=0, o_misalign=0.
  - o_alu_ready and o_lsu_ready are forced 0 while i_rst is high.
  - Reset mid-transfer discards buffered entries; no write issues for them.
- Buffers: one entry per channel, holding a full flag and payload.
- Grant (combinational, from full flags and rr only; no dependence on valid inputs):
  - only one buffer full -> grant that one.
  - both full -> grant the channel named by rr, then set rr to the other channel.
  - neither full -> no grant; rr unchanged.
- Ready: ready_x = ~full_x | grant_x. This permits same-edge drain and refill, so a single channel sustains 1 entry/cycle.
- Buffer update at edge:
  - accept (valid & ready) -> full, payload captured.
  - granted and not refilled -> empty.
- Output register, loaded at every edge from the granted entry:
  - o_write = grant & legal.
  - o_rd_no and o_rd_dat take the granted entry; they hold their previous values when there is no grant.
  - pulse outputs are 0 when there is no grant.
- Latency: an entry accepted at edge N can be granted in cycle N+1. o_write appears after edge N+1, and the register file writes at edge N+2.
- Legality (evaluated at grant):
  - rd == 0 -> consumes the grant, o_write=0, no flag.
  - rd[REGNO_W-1:5] != 0 -> o_write=0, o_illegal_rd=1.
- Load extension, with lane = i_lsu_off:
  - 000 LB: sign-extend byte at lane.
  - 100 LBU: zero-extend byte at lane.
  - 001 LH: sign-extend halfword at off[1]; off[0]=1 is misaligned.
  - 101 LHU: zero-extend halfword at off[1]; off[0]=1 is misaligned.
  - 010 LW: full word; off != 0 is misaligned.
  - any other funct3 -> treated as misaligned.
  - Misaligned -> o_write=0, o_misalign=1.
- A misaligned load with rd=0 sets o_misalign only.
- Extension is applied on the buffer's registered payload; the output stage stores the extended value.

Optional Feature:
- Macro RF_WRITEBACK_RETIRE_CNT_EN.
- Defined: adds output o_retire_cnt (64 bits), reset 0.
  - Increments by 1 at every edge where a grant occurs, whether or not the entry is legal.
  - Wraps from 2^64-1 to 0.
  - Counts the granted entry even when i_rst is not asserted and the write is suppressed.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- ALU only: valid held 1 for 4 cycles, rd=5,6,7,8, dat=0x11..0x44 -> ready stays 1; o_write high for 4 consecutive cycles starting 2 edges after the first accept, in order.
- Both channels valid every cycle (ALU rd=3 dat=0xA, LSU rd=4 LW word=0xDEADBEEF off=0), starting from reset -> writes alternate LSU, ALU, LSU, ALU; each channel's ready alternates 0/1.
- Loads with word=0x8070F0FF: LB off=1 -> 0xFFFFFFF0; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF8070; LHU off=0 -> 0x0000F0FF.
- LW off=2 rd=9 -> o_misalign pulse, o_write=0. ALU rd=0 -> no write, no flag. ALU rd=33 -> o_illegal_rd pulse, no write.
- Both buffers full, i_rst asserted one cycle -> no further o_write; readies 0 during reset; rr restarts at LSU.
- With RF_WRITEBACK_RETIRE_CNT_EN: 10 grants including 2 dropped -> o_retire_cnt=10.

Source files
------------

// File: rtl/rf_writeback.sv
// rf_writeback: register-file writeback stage.
// Two result producers (ALU and load unit) each feed a one-entry buffer with a
// valid/ready handshake. A round-robin arbiter picks one full buffer per cycle.
// The granted entry is checked for legality and loaded into the output register.
// Load data is sign- or zero-extended from the registered raw word.
// Optional feature: define RF_WRITEBACK_RETIRE_CNT_EN to add a 64-bit count of grants (o_retire_cnt).
module rf_writeback #(
  parameter int XLEN    = 32,
  parameter int REGNO_W = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_alu_valid,
  output logic               o_alu_ready,
  input  logic [REGNO_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]    i_alu_dat,
  input  logic               i_lsu_valid,
  output logic               o_lsu_ready,
  input  logic [REGNO_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]    i_lsu_word,
  input  logic [1:0]         i_lsu_off,
  input  logic [2:0]         i_lsu_funct3,
  output logic [XLEN-1:0]    o_rd_dat,
  output logic [REGNO_W-1:0] o_rd_no,
  output logic               o_write,
  output logic               o_illegal_rd,
`ifdef RF_WRITEBACK_RETIRE_CNT_EN
  output logic [63:0]        o_retire_cnt,
`endif
  output logic               o_misalign
);

  // Extract and extend the addressed byte/halfword of an aligned memory word.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      3'b010:  r = word;
      default: r = word;
    endcase
    return r;
  endfunction

  // Misalignment check; unknown load types are rejected the same way.
  function automatic logic load_misaligned(input logic [1:0] off, input logic [2:0] f3);
    logic m;
    case (f3)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = off[0];
      3'b010:         m = (off != 2'd0);
      default:        m = 1'b1;
    endcase
    return m;
  endfunction

  logic               alu_full_r;
  logic [REGNO_W-1:0] alu_rd_r;
  logic [XLEN-1:0]    alu_dat_r;
  logic               lsu_full_r;
  logic [REGNO_W-1:0] lsu_rd_r;
  logic [XLEN-1:0]    lsu_word_r;
  logic [1:0]         lsu_off_r;
  logic [2:0]         lsu_funct3_r;
  logic               rr_alu_r;     // 1: ALU wins next tie, 0: LSU wins next tie

  logic               grant_alu_s;
  logic               grant_lsu_s;
  logic               any_grant_s;
  logic [REGNO_W-1:0] sel_rd_s;
  logic [XLEN-1:0]    sel_dat_s;
  logic               sel_mis_s;
  logic               illegal_s;
  logic               write_s;
  logic               alu_acc_s;
  logic               lsu_acc_s;

  // Arbitration from buffer occupancy and round-robin pointer only.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (alu_full_r && lsu_full_r) begin
      if (rr_alu_r) grant_alu_s = 1'b1;
      else          grant_lsu_s = 1'b1;
    end else if (alu_full_r) begin
      grant_alu_s = 1'b1;
    end else if (lsu_full_r) begin
      grant_lsu_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
    end
  end

  assign any_grant_s = grant_alu_s | grant_lsu_s;
  // A granted buffer may refill on the same edge it drains.
  assign o_alu_ready = ~i_rst & (~alu_full_r | grant_alu_s);
  assign o_lsu_ready = ~i_rst & (~lsu_full_r | grant_lsu_s);
  assign alu_acc_s   = i_alu_valid & o_alu_ready;
  assign lsu_acc_s   = i_lsu_valid & o_lsu_ready;

  // Select the granted entry and evaluate legality of its write.
  always_comb begin
    sel_rd_s  = {REGNO_W{1'b0}};
    sel_dat_s = {XLEN{1'b0}};
    sel_mis_s = 1'b0;
    if (grant_alu_s) begin
      sel_rd_s  = alu_rd_r;
      sel_dat_s = alu_dat_r;
    end else if (grant_lsu_s) begin
      sel_rd_s  = lsu_rd_r;
      sel_dat_s = load_ext(lsu_word_r, lsu_off_r, lsu_funct3_r);
      sel_mis_s = load_misaligned(lsu_off_r, lsu_funct3_r);
    end else begin
      sel_mis_s = 1'b0;
    end
    illegal_s = any_grant_s & (|sel_rd_s[REGNO_W-1:5]);
    write_s   = any_grant_s & ~illegal_s & ~sel_mis_s & (sel_rd_s != {REGNO_W{1'b0}});
  end

  // Input buffers and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      alu_full_r   <= 1'b0;
      alu_rd_r     <= {REGNO_W{1'b0}};
      alu_dat_r    <= {XLEN{1'b0}};
      lsu_full_r   <= 1'b0;
      lsu_rd_r     <= {REGNO_W{1'b0}};
      lsu_word_r   <= {XLEN{1'b0}};
      lsu_off_r    <= 2'd0;
      lsu_funct3_r <= 3'd0;
      rr_alu_r     <= 1'b0;
    end else begin
      if (alu_acc_s) begin
        alu_full_r <= 1'b1;
        alu_rd_r   <= i_alu_rd;
        alu_dat_r  <= i_alu_dat;
      end else if (grant_alu_s) begin
        alu_full_r <= 1'b0;
      end
      if (lsu_acc_s) begin
        lsu_full_r   <= 1'b1;
        lsu_rd_r     <= i_lsu_rd;
        lsu_word_r   <= i_lsu_word;
        lsu_off_r    <= i_lsu_off;
        lsu_funct3_r <= i_lsu_funct3;
      end else if (grant_lsu_s) begin
        lsu_full_r <= 1'b0;
      end
      if (alu_full_r && lsu_full_r) begin
        rr_alu_r <= ~rr_alu_r;
      end
    end
  end

  // Registered write port and drop-indication pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_write      <= 1'b0;
      o_rd_no      <= {REGNO_W{1'b0}};
      o_rd_dat     <= {XLEN{1'b0}};
      o_illegal_rd <= 1'b0;
      o_misalign   <= 1'b0;
    end else begin
      o_write      <= write_s;
      o_illegal_rd <= illegal_s;
      o_misalign   <= any_grant_s & sel_mis_s;
      if (any_grant_s) begin
        o_rd_no  <= sel_rd_s;
        o_rd_dat <= sel_dat_s;
      end
    end
  end

`ifdef RF_WRITEBACK_RETIRE_CNT_EN
  // Count every granted entry, legal or dropped; wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_retire_cnt <= 64'd0;
    end else if (any_grant_s) begin
      o_retire_cnt <= o_retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback.
module tb_rf_writeback;

  localparam int XLEN    = 32;
  localparam int REGNO_W = 6;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_alu_valid;
  logic               o_alu_ready;
  logic [REGNO_W-1:0] i_alu_rd;
  logic [XLEN-1:0]    i_alu_dat;
  logic               i_lsu_valid;
  logic               o_lsu_ready;
  logic [REGNO_W-1:0] i_lsu_rd;
  logic [XLEN-1:0]    i_lsu_word;
  logic [1:0]         i_lsu_off;
  logic [2:0]         i_lsu_funct3;
  logic [XLEN-1:0]    o_rd_dat;
  logic [REGNO_W-1:0] o_rd_no;
  logic               o_write;
  logic               o_illegal_rd;
  logic               o_misalign;
`ifdef RF_WRITEBACK_RETIRE_CNT_EN
  logic [63:0]        o_retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rf_writeback #(.XLEN(XLEN), .REGNO_W(REGNO_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_alu_valid  (i_alu_valid),
    .o_alu_ready  (o_alu_ready),
    .i_alu_rd     (i_alu_rd),
    .i_alu_dat    (i_alu_dat),
    .i_lsu_valid  (i_lsu_valid),
    .o_lsu_ready  (o_lsu_ready),
    .i_lsu_rd     (i_lsu_rd),
    .i_lsu_word   (i_lsu_word),
    .i_lsu_off    (i_lsu_off),
    .i_lsu_funct3 (i_lsu_funct3),
    .o_rd_dat     (o_rd_dat),
    .o_rd_no      (o_rd_no),
    .o_write      (o_write),
    .o_illegal_rd (o_illegal_rd),
`ifdef RF_WRITEBACK_RETIRE_CNT_EN
    .o_retire_cnt (o_retire_cnt),
`endif
    .o_misalign   (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_alu_valid  = 1'b0;
    i_alu_rd     = '0;
    i_alu_dat    = '0;
    i_lsu_valid  = 1'b0;
    i_lsu_rd     = '0;
    i_lsu_word   = '0;
    i_lsu_off    = 2'd0;
    i_lsu_funct3 = 3'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    total++;
    if ({o_write, o_illegal_rd, o_misalign} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {o_write, o_illegal_rd, o_misalign});
    end
    total++;
    if (o_rd_no !== 6'd0 || o_rd_dat !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%0d/%h exp=0/0", o_rd_no, o_rd_dat);
    end
    total++;
    if ({o_alu_ready, o_lsu_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b exp=00", {o_alu_ready, o_lsu_ready});
    end
    i_rst = 1'b0;
    #1;
    total++;
    if ({o_alu_ready, o_lsu_ready} !== 2'b11) begin
      bad++; $display("FAIL post_reset_ready got=%b exp=11", {o_alu_ready, o_lsu_ready});
    end
  endtask

  task automatic test_alu_stream;
    logic [31:0] dats [4];
    dats[0] = 32'h11; dats[1] = 32'h22; dats[2] = 32'h33; dats[3] = 32'h44;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        i_alu_valid = 1'b1;
        i_alu_rd    = 6'(5 + i);
        i_alu_dat   = dats[i];
        #1;
        total++;
        if (o_alu_ready !== 1'b1) begin
          bad++; $display("FAIL alu_ready step=%0d got=%b exp=1", i, o_alu_ready);
        end
      end else begin
        i_alu_valid = 1'b0;
      end
      if (i >= 2 && i < 6) begin
        total++;
        if (o_write !== 1'b1 || o_rd_no !== 6'(5 + i - 2) || o_rd_dat !== dats[i-2]) begin
          bad++; $display("FAIL alu_write step=%0d got=%b/%0d/%h exp=1/%0d/%h",
                          i, o_write, o_rd_no, o_rd_dat, 5 + i - 2, dats[i-2]);
        end
      end else begin
        total++;
        if (o_write !== 1'b0) begin
          bad++; $display("FAIL alu_idle step=%0d got=%b exp=0", i, o_write);
        end
      end
      tick();
    end
  endtask

  task automatic test_alternate;
    do_reset();
    i_alu_valid = 1'b1; i_alu_rd = 6'd3; i_alu_dat = 32'hA;
    i_lsu_valid = 1'b1; i_lsu_rd = 6'd4; i_lsu_word = 32'hDEADBEEF;
    i_lsu_off = 2'd0; i_lsu_funct3 = 3'b010;
    #1;
    for (int k = 0; k < 7; k++) begin
      total++;
      if (k == 0) begin
        if ({o_alu_ready, o_lsu_ready} !== 2'b11) begin
          bad++; $display("FAIL alt_ready k=%0d got=%b exp=11", k, {o_alu_ready, o_lsu_ready});
        end
      end else if ({o_alu_ready, o_lsu_ready} !== {~k[0], k[0]}) begin
        bad++; $display("FAIL alt_ready k=%0d got=%b exp=%b", k, {o_alu_ready, o_lsu_ready}, {~k[0], k[0]});
      end
      total++;
      if (k < 2) begin
        if (o_write !== 1'b0) begin
          bad++; $display("FAIL alt_idle k=%0d got=%b exp=0", k, o_write);
        end
      end else if (k[0] == 1'b0) begin
        if (o_write !== 1'b1 || o_rd_no !== 6'd4 || o_rd_dat !== 32'hDEADBEEF) begin
          bad++; $display("FAIL alt_lsu k=%0d got=%b/%0d/%h exp=1/4/deadbeef", k, o_write, o_rd_no, o_rd_dat);
        end
      end else begin
        if (o_write !== 1'b1 || o_rd_no !== 6'd3 || o_rd_dat !== 32'hA) begin
          bad++; $display("FAIL alt_alu k=%0d got=%b/%0d/%h exp=1/3/a", k, o_write, o_rd_no, o_rd_dat);
        end
      end
      tick();
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [4];
    logic [1:0]  offs [4];
    logic [31:0] exps [4];
    f3s[0] = 3'b000; offs[0] = 2'd1; exps[0] = 32'hFFFFFFF0;
    f3s[1] = 3'b100; offs[1] = 2'd3; exps[1] = 32'h00000080;
    f3s[2] = 3'b001; offs[2] = 2'd2; exps[2] = 32'hFFFF8070;
    f3s[3] = 3'b101; offs[3] = 2'd0; exps[3] = 32'h0000F0FF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_lsu_valid = 1'b1; i_lsu_rd = 6'(10 + i); i_lsu_word = 32'h8070F0FF;
      i_lsu_off = offs[i]; i_lsu_funct3 = f3s[i];
      tick();
      i_lsu_valid = 1'b0;
      tick();
      total++;
      if (o_write !== 1'b1 || o_misalign !== 1'b0 || o_rd_no !== 6'(10 + i) || o_rd_dat !== exps[i]) begin
        bad++; $display("FAIL load_ext i=%0d got=%b/%b/%0d/%h exp=1/0/%0d/%h",
                        i, o_write, o_misalign, o_rd_no, o_rd_dat, 10 + i, exps[i]);
      end
      tick();
      total++;
      if (o_write !== 1'b0) begin
        bad++; $display("FAIL load_once i=%0d got=%b exp=0", i, o_write);
      end
    end
  endtask

  task automatic test_drops;
    do_reset();
    // Misaligned word load
    i_lsu_valid = 1'b1; i_lsu_rd = 6'd9; i_lsu_word = 32'h12345678;
    i_lsu_off = 2'd2; i_lsu_funct3 = 3'b010;
    tick();
    i_lsu_valid = 1'b0;
    tick();
    total++;
    if ({o_write, o_misalign, o_illegal_rd} !== 3'b010) begin
      bad++; $display("FAIL misalign got=%b exp=010", {o_write, o_misalign, o_illegal_rd});
    end
    tick();
    total++;
    if (o_misalign !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse got=%b exp=0", o_misalign);
    end
    // ALU write to x0
    i_alu_valid = 1'b1; i_alu_rd = 6'd0; i_alu_dat = 32'h55;
    tick();
    i_alu_valid = 1'b0;
    tick();
    total++;
    if ({o_write, o_misalign, o_illegal_rd} !== 3'b000) begin
      bad++; $display("FAIL rd_zero got=%b exp=000", {o_write, o_misalign, o_illegal_rd});
    end
    // ALU write to register 33
    i_alu_valid = 1'b1; i_alu_rd = 6'd33; i_alu_dat = 32'h66;
    tick();
    i_alu_valid = 1'b0;
    tick();
    total++;
    if ({o_write, o_misalign, o_illegal_rd} !== 3'b001) begin
      bad++; $display("FAIL illegal_rd got=%b exp=001", {o_write, o_misalign, o_illegal_rd});
    end
    tick();
    total++;
    if (o_illegal_rd !== 1'b0) begin
      bad++; $display("FAIL illegal_pulse got=%b exp=0", o_illegal_rd);
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    i_alu_valid = 1'b1; i_alu_rd = 6'd3; i_alu_dat = 32'hA;
    i_lsu_valid = 1'b1; i_lsu_rd = 6'd4; i_lsu_word = 32'hDEADBEEF;
    i_lsu_off = 2'd0; i_lsu_funct3 = 3'b010;
    tick();
    i_rst = 1'b1;
    i_alu_valid = 1'b0;
    i_lsu_valid = 1'b0;
    #1;
    total++;
    if ({o_alu_ready, o_lsu_ready} !== 2'b00) begin
      bad++; $display("FAIL midrst_ready got=%b exp=00", {o_alu_ready, o_lsu_ready});
    end
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (o_write !== 1'b0) begin
        bad++; $display("FAIL midrst_nowrite step=%0d got=%b exp=0", i, o_write);
      end
      tick();
    end
    i_alu_valid = 1'b1;
    i_lsu_valid = 1'b1;
    tick();
    tick();
    total++;
    if (o_write !== 1'b1 || o_rd_no !== 6'd4) begin
      bad++; $display("FAIL midrst_rr got=%b/%0d exp=1/4", o_write, o_rd_no);
    end
    idle_inputs();
    repeat (4) tick();
  endtask

`ifdef RF_WRITEBACK_RETIRE_CNT_EN
  task automatic test_retire_cnt;
    do_reset();
    total++;
    if (o_retire_cnt !== 64'd0) begin
      bad++; $display("FAIL retire_reset got=%0d exp=0", o_retire_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      i_alu_valid = 1'b1;
      i_alu_rd    = (i == 3 || i == 7) ? 6'd0 : 6'd5;
      i_alu_dat   = 32'(i);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    total++;
    if (o_retire_cnt !== 64'd10) begin
      bad++; $display("FAIL retire_cnt got=%0d exp=10", o_retire_cnt);
    end
  endtask
`endif

  initial begin
    i_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_stream();
    test_alternate();
    test_loads();
    test_drops();
    test_mid_reset();
`ifdef RF_WRITEBACK_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
